// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: clears all registers after reset, then arbitrates two buffered write requesters round-robin onto one register-file write port.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_val,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_val,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_val,
  output logic              busy,
  output logic [3:0]        pending
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_reg_q, wr_reg_d, a_reg_q, a_reg_d, b_reg_q, b_reg_d;
  logic [DATA_W-1:0] wr_val_q, wr_val_d, a_val_q, a_val_d, b_val_q, b_val_d;
  logic wr_en_q, wr_en_d, held_a_q, held_a_d, held_b_q, held_b_d, ptr_b_q, ptr_b_d;
  logic run, grant_a, grant_b, take_a, take_b;
  // ptr_b_q high means B was granted most recently, so A wins the next tie
  assign run     = (state_q == RUN) && !rst;
  assign grant_a = run && held_a_q && (!held_b_q || ptr_b_q);
  assign grant_b = run && held_b_q && (!held_a_q || !ptr_b_q);
  assign a_ready = run && (!held_a_q || grant_a);
  assign b_ready = run && (!held_b_q || grant_b);
  assign take_a  = a_valid && a_ready;
  assign take_b  = b_valid && b_ready;
  assign busy    = rst || (state_q == CLEAR);
  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_val  = wr_val_q;
  always_comb begin
    pending = '0;
    for (int r = 0; r < 4; r++)
      pending[r] = !rst && ((held_a_q && a_reg_q == ADDR_W'(r)) || (held_b_q && b_reg_q == ADDR_W'(r)));
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en_d  = grant_a || grant_b;
    wr_reg_d = grant_a ? a_reg_q : grant_b ? b_reg_q : wr_reg_q;
    wr_val_d = grant_a ? a_val_q : grant_b ? b_val_q : wr_val_q;
    if (state_q == CLEAR) begin
      wr_en_d  = 1'b1;
      wr_reg_d = cnt_q;
      wr_val_d = '0;
      cnt_d    = cnt_q + 1'b1;
      state_d  = &cnt_q ? RUN : CLEAR;
    end
    held_a_d = take_a || (held_a_q && !grant_a);
    held_b_d = take_b || (held_b_q && !grant_b);
    a_reg_d  = take_a ? a_reg : a_reg_q;
    a_val_d  = take_a ? a_val : a_val_q;
    b_reg_d  = take_b ? b_reg : b_reg_q;
    b_val_d  = take_b ? b_val : b_val_q;
    ptr_b_d  = grant_b ? 1'b1 : grant_a ? 1'b0 : ptr_b_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_reg_q <= '0;
      wr_val_q <= '0;
      held_a_q <= 1'b0;
      held_b_q <= 1'b0;
      a_reg_q  <= '0;
      a_val_q  <= '0;
      b_reg_q  <= '0;
      b_val_q  <= '0;
      ptr_b_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      wr_reg_q <= wr_reg_d;
      wr_val_q <= wr_val_d;
      held_a_q <= held_a_d;
      held_b_q <= held_b_d;
      a_reg_q  <= a_reg_d;
      a_val_q  <= a_val_d;
      b_reg_q  <= b_reg_d;
      b_val_q  <= b_val_d;
      ptr_b_q  <= ptr_b_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus pushes expected writes into a queue; a negedge monitor pops and compares every DUT write.
module tb_regfile_write_arbiter;
  logic clk = 0, rst = 1;
  logic a_valid = 0, b_valid = 0, a_ready, b_ready, wr_en, busy;
  logic [1:0] a_reg = 0, b_reg = 0, wr_reg;
  logic [7:0] a_val = 0, b_val = 0, wr_val;
  logic [3:0] pending;
  logic [9:0] exp_q[$];
  logic [7:0] rf[4];
  int tot = 0, pass = 0;

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_val(a_val),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_val(b_val),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_val(wr_val), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tot++;
        $display("FAIL unexpected_write: got reg %0d val %0h expected no write", wr_reg, wr_val);
      end else begin
        chk("write", {22'd0, wr_reg, wr_val}, {22'd0, exp_q.pop_front()});
      end
      rf[wr_reg] = wr_val;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_pending", pending, 0);
    tick;
    tick;
    for (int i = 0; i < 4; i++) exp_q.push_back({i[1:0], 8'h00});
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      @(negedge clk);
      chk("clr_busy", busy, i < 3);
      chk("clr_a_ready", a_ready, i == 3);
      chk("clr_b_ready", b_ready, i == 3);
      chk("clr_pending", pending, 0);
    end
    tick;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] v[3];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
    do_reset;
    drain("drain_clear");
    // A alone, three back-to-back requests to reg 1
    a_reg = 1;
    a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_val = v[i];
      exp_q.push_back({2'd1, v[i]});
      @(negedge clk);
      chk("a_only_a_ready", a_ready, 1);
      chk("a_only_b_ready", b_ready, 1);
      chk("a_only_wr_en", wr_en, i == 2);
      tick;
    end
    a_valid = 0;
    @(negedge clk);
    chk("a_only_wr_en_tail", wr_en, 1);
    drain("drain_a_only");
    // Both continuously valid: alternation starting with A after reset
    do_reset;
    a_reg = 0; a_val = 8'hAA; b_reg = 2; b_val = 8'hBB;
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 5; i++) exp_q.push_back((i % 2 == 0) ? {2'd0, 8'hAA} : {2'd2, 8'hBB});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_a_ready", a_ready, i == 0 || i % 2 == 1);
      chk("alt_b_ready", b_ready, i == 0 || i % 2 == 0);
      if (i > 0) chk("alt_pending", pending, 4'b0101);
      tick;
    end
    a_valid = 0; b_valid = 0;
    drain("drain_alt");
    // Same target register from both requesters
    do_reset;
    a_reg = 3; a_val = 8'h01; b_reg = 3; b_val = 8'h02;
    a_valid = 1; b_valid = 1;
    exp_q.push_back({2'd3, 8'h01});
    exp_q.push_back({2'd3, 8'h02});
    tick;
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("same_pending", pending, 4'b1000);
    chk("same_a_ready", a_ready, 1);
    chk("same_b_ready", b_ready, 0);
    drain("drain_same");
    chk("same_final_rf3", rf[3], 8'h02);
    // Reset while B is held and A is writing: B must never issue
    a_reg = 1; a_val = 8'h5A; b_reg = 2; b_val = 8'hB5;
    a_valid = 1; b_valid = 1;
    exp_q.push_back({2'd1, 8'h5A});
    tick;
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("mid_pending", pending, 4'b0110);
    tick;
    do_reset;
    drain("drain_mid_rst");
    chk("mid_rst_pending", pending, 0);
    // Request held high through CLEAR is accepted on the first RUN edge
    a_reg = 2; a_val = 8'h42; a_valid = 1;
    do_reset;
    a_valid = 0;
    exp_q.push_back({2'd2, 8'h42});
    @(negedge clk);
    chk("clr_req_pending", pending, 4'b0100);
    drain("drain_clr_req");
    repeat (3) tick;
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
